// File: rtl/pacman_pkg.sv
// Shared constants, state encoding and the prescaler reload helper for the
// pacman game controller and its neighbours (renderer, maze logic).
package pacman_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READY     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_DYING     = 3'd3,
    ST_LEVEL_UP  = 3'd4,
    ST_GAME_OVER = 3'd5
  } state_e;

  localparam int unsigned TICK_RELOAD_DEF = 500000;
  localparam int unsigned TILE_SIZE       = 8;
  localparam int unsigned GRID_W          = 28;
  localparam int unsigned GRID_H          = 31;
  localparam int unsigned PHASE_W         = 16;

  // Faster ticks per level, but never below one step so high levels cannot wrap.
  function automatic logic [31:0] calc_reload(input logic [2:0] lvl,
                                              input int unsigned base,
                                              input int unsigned step);
    int unsigned drop;
    drop = 32'(lvl) * step;
    if (drop + step > base) calc_reload = step;
    else                    calc_reload = base - drop;
  endfunction

endpackage

// File: rtl/pacman_tick_gen.sv
// Down-counting prescaler: ticks when the count reaches zero and reloads in
// the same cycle, giving a period of reload+1 enabled cycles.
module pacman_tick_gen #(
  parameter int unsigned RELOAD_INIT = 500000
) (
  input  logic        clk_pix,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load,
  input  logic [31:0] reload,
  output logic        tick
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (load) begin
      cnt_d = reload;
    end else if (enable) begin
      if (cnt_q == '0) begin
        tick  = 1'b1;
        cnt_d = reload;
      end else begin
        cnt_d = cnt_q - 32'd1;
      end
    end
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) cnt_q <= RELOAD_INIT;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pacman_game_ctrl.sv
// Pacman game flow controller: start/ready/play/dying/level-up/game-over
// sequencing, lives and level bookkeeping, and the movement tick strobe.
module pacman_game_ctrl
  import pacman_pkg::*;
#(
  parameter int unsigned TICK_RELOAD   = TICK_RELOAD_DEF,
  parameter int unsigned TICK_STEP     = 50000,
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned READY_TICKS   = 20,
  parameter int unsigned DEATH_TICKS   = 12,
  parameter int unsigned LEVELUP_TICKS = 16,
  parameter int unsigned LEVEL_MAX     = 7
) (
  input  logic       clk_pix,
  input  logic       rst_n,
  input  logic       game_active,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       hit,
  input  logic       board_clear,
  output logic       move_tick,
  output logic       reset_actors,
  output logic       reset_board,
  output logic [1:0] lives,
  output logic [2:0] level,
  output logic [2:0] phase,
  output logic       game_over
);

  state_e               state_q, state_d;
  logic [1:0]           lives_q, lives_d;
  logic [2:0]           level_q, level_d;
  logic [PHASE_W-1:0]   phase_cnt_q, phase_cnt_d;
  logic                 btn_l_prev_q, btn_r_prev_q;
  logic                 move_tick_q, move_tick_d;
  logic                 reset_actors_q, reset_actors_d;
  logic                 reset_board_q, reset_board_d;

  logic                 press, start, tick, phase_done;
  logic [PHASE_W-1:0]   phase_last;
  logic [31:0]          tick_reload;

  assign press = game_active & ((btn_left & ~btn_l_prev_q) | (btn_right & ~btn_r_prev_q));
  assign start = press & ((state_q == ST_IDLE) | (state_q == ST_GAME_OVER));

  // A new game always runs at level 0 speed, even before level_q is cleared.
  assign tick_reload = start ? calc_reload(3'd0, TICK_RELOAD, TICK_STEP)
                             : calc_reload(level_q, TICK_RELOAD, TICK_STEP);

  pacman_tick_gen #(
    .RELOAD_INIT(TICK_RELOAD)
  ) u_tick_gen (
    .clk_pix (clk_pix),
    .rst_n   (rst_n),
    .enable  (game_active),
    .load    (start),
    .reload  (tick_reload),
    .tick    (tick)
  );

  always_comb begin
    case (state_q)
      ST_READY:    phase_last = PHASE_W'(READY_TICKS - 1);
      ST_DYING:    phase_last = PHASE_W'(DEATH_TICKS - 1);
      ST_LEVEL_UP: phase_last = PHASE_W'(LEVELUP_TICKS - 1);
      default:     phase_last = '0;
    endcase
  end
  assign phase_done = tick & (phase_cnt_q == phase_last);

  always_comb begin
    state_d        = state_q;
    lives_d        = lives_q;
    level_d        = level_q;
    phase_cnt_d    = phase_cnt_q;
    move_tick_d    = 1'b0;
    reset_actors_d = 1'b0;
    reset_board_d  = 1'b0;
    if (game_active) begin
      case (state_q)
        ST_IDLE, ST_GAME_OVER: begin
          if (press) begin
            state_d        = ST_READY;
            lives_d        = 2'(LIVES_INIT);
            level_d        = '0;
            phase_cnt_d    = '0;
            reset_actors_d = 1'b1;
            reset_board_d  = 1'b1;
          end
        end
        ST_READY: begin
          if (phase_done) begin
            state_d     = ST_PLAY;
            phase_cnt_d = '0;
          end else if (tick) begin
            phase_cnt_d = phase_cnt_q + 1'b1;
          end
        end
        ST_PLAY: begin
          move_tick_d = tick;
          if (tick && hit) begin
            state_d     = ST_DYING;
            phase_cnt_d = '0;
          end else if (tick && board_clear) begin
            state_d     = ST_LEVEL_UP;
            phase_cnt_d = '0;
          end
        end
        ST_DYING: begin
          if (phase_done) begin
            phase_cnt_d = '0;
            if (lives_q == 2'd1) begin
              state_d = ST_GAME_OVER;
              lives_d = '0;
            end else begin
              state_d        = ST_READY;
              lives_d        = lives_q - 2'd1;
              reset_actors_d = 1'b1;
            end
          end else if (tick) begin
            phase_cnt_d = phase_cnt_q + 1'b1;
          end
        end
        ST_LEVEL_UP: begin
          if (phase_done) begin
            state_d        = ST_READY;
            phase_cnt_d    = '0;
            level_d        = (level_q >= 3'(LEVEL_MAX)) ? 3'(LEVEL_MAX) : level_q + 3'd1;
            reset_actors_d = 1'b1;
            reset_board_d  = 1'b1;
          end else if (tick) begin
            phase_cnt_d = phase_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      lives_q        <= '0;
      level_q        <= '0;
      phase_cnt_q    <= '0;
      btn_l_prev_q   <= 1'b0;
      btn_r_prev_q   <= 1'b0;
      move_tick_q    <= 1'b0;
      reset_actors_q <= 1'b0;
      reset_board_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      lives_q        <= lives_d;
      level_q        <= level_d;
      phase_cnt_q    <= phase_cnt_d;
      btn_l_prev_q   <= btn_left;
      btn_r_prev_q   <= btn_right;
      move_tick_q    <= move_tick_d;
      reset_actors_q <= reset_actors_d;
      reset_board_q  <= reset_board_d;
    end
  end

  assign move_tick    = move_tick_q;
  assign reset_actors = reset_actors_q;
  assign reset_board  = reset_board_q;
  assign lives        = lives_q;
  assign level        = level_q;
  assign phase        = state_q;
  assign game_over    = (state_q == ST_GAME_OVER);

endmodule

// File: tb/tb_pacman_game_ctrl.sv
// Directed bench for pacman_game_ctrl with a small scoreboard of expected
// values, using short tick/phase lengths so whole games fit in a few hundred cycles.
module tb_pacman_game_ctrl;

  logic       clk_pix = 1'b0;
  logic       rst_n = 1'b0;
  logic       game_active = 1'b1;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       hit = 1'b0;
  logic       board_clear = 1'b0;
  logic       move_tick, reset_actors, reset_board, game_over;
  logic [1:0] lives;
  logic [2:0] level, phase;

  int    n_assert = 0;
  int    n_fail = 0;
  string tag_q[$];
  int    exp_q[$];

  pacman_game_ctrl #(
    .TICK_RELOAD(3), .TICK_STEP(1), .LIVES_INIT(3),
    .READY_TICKS(2), .DEATH_TICKS(2), .LEVELUP_TICKS(2), .LEVEL_MAX(7)
  ) dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .game_active(game_active),
    .btn_left(btn_left), .btn_right(btn_right), .hit(hit), .board_clear(board_clear),
    .move_tick(move_tick), .reset_actors(reset_actors), .reset_board(reset_board),
    .lives(lives), .level(level), .phase(phase), .game_over(game_over)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic step();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic push(input string tag, input int exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic check(input int obs);
    string tag;
    int    exp;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %0d expected none", obs);
      return;
    end
    tag = tag_q.pop_front();
    exp = exp_q.pop_front();
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %s observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk(input string tag, input int exp, input int obs);
    push(tag, exp);
    check(obs);
  endtask

  task automatic wait_phase(input int tgt, input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (int'(phase) == tgt) begin cyc = i; break; end
    end
  endtask

  task automatic wait_leave(input int cur, input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (int'(phase) != cur) begin cyc = i; break; end
    end
  endtask

  task automatic wait_move(input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (move_tick) begin cyc = i; break; end
    end
  endtask

  initial begin
    int cyc, moves, changes, pulses;

    // reset state
    step(); step();
    chk("rst_phase", 0, int'(phase));
    chk("rst_lives", 0, int'(lives));
    chk("rst_level", 0, int'(level));
    chk("rst_game_over", 0, int'(game_over));
    chk("rst_pulses", 0, int'({move_tick, reset_actors, reset_board}));
    rst_n = 1'b1;
    step();
    chk("idle_after_release", 0, int'({phase, move_tick, reset_actors, reset_board}));

    // new game: one-cycle reset pulses, READY lasts 2 ticks of 4 cycles
    btn_left = 1'b1;
    push("start_phase", 1); push("start_lives", 3); push("start_pulses", 3);
    step();
    check(int'(phase)); check(int'(lives)); check(int'({reset_board, reset_actors}));
    btn_left = 1'b0;
    step();
    chk("start_pulse_width", 0, int'({reset_board, reset_actors}));
    push("ready_len", 8);
    wait_phase(2, 20, cyc);
    check(cyc < 0 ? -1 : cyc + 1);
    push("first_move", 4);
    wait_move(20, cyc); check(cyc);
    push("move_period_l0", 4);
    wait_move(20, cyc); check(cyc);

    // hit and board_clear together: hit wins
    hit = 1'b1; board_clear = 1'b1;
    push("hit_wins", 4);
    wait_phase(3, 20, cyc); check(cyc);
    hit = 1'b0; board_clear = 1'b0;
    chk("dying_level", 0, int'(level));
    chk("dying_lives", 3, int'(lives));
    push("dying_len", 8);
    wait_leave(3, 20, cyc); check(cyc);
    chk("after_death_phase", 1, int'(phase));
    chk("after_death_lives", 2, int'(lives));
    chk("after_death_pulses", 1, int'({reset_board, reset_actors}));

    // level up
    wait_phase(2, 20, cyc);
    board_clear = 1'b1;
    wait_phase(4, 20, cyc);
    board_clear = 1'b0;
    chk("levelup_entry_level", 0, int'(level));
    wait_leave(4, 20, cyc);
    chk("levelup_exit_phase", 1, int'(phase));
    chk("levelup_level", 1, int'(level));
    chk("levelup_pulses", 3, int'({reset_board, reset_actors}));
    chk("levelup_lives", 2, int'(lives));
    wait_phase(2, 20, cyc);
    wait_move(20, cyc);
    push("move_period_l1", 3);
    wait_move(20, cyc); check(cyc);

    // two more deaths end the game
    for (int k = 0; k < 2; k++) begin
      if (k == 1) wait_phase(2, 20, cyc);
      hit = 1'b1;
      wait_phase(3, 20, cyc);
      hit = 1'b0;
      wait_leave(3, 20, cyc);
      chk("death_lives", 1 - k, int'(lives));
      chk("death_phase", (k == 0) ? 1 : 5, int'(phase));
    end
    chk("game_over_flag", 1, int'(game_over));
    chk("game_over_no_pulse", 0, int'({reset_board, reset_actors}));
    chk("game_over_level", 1, int'(level));

    // a press made while frozen is not acted on after resuming
    game_active = 1'b0;
    step();
    btn_left = 1'b1;
    step(); step(); step();
    game_active = 1'b1;
    step(); step(); step();
    chk("frozen_press_ignored", 5, int'(phase));
    btn_left = 1'b0;
    step();
    btn_right = 1'b1;
    step();
    btn_right = 1'b0;
    chk("restart_phase", 1, int'(phase));
    chk("restart_lives", 3, int'(lives));
    chk("restart_level", 0, int'(level));
    chk("restart_pulses", 3, int'({reset_board, reset_actors}));

    // freeze for 100 cycles in PLAY with the button toggling
    wait_phase(2, 20, cyc);
    wait_move(20, cyc);
    game_active = 1'b0;
    moves = 0; changes = 0; pulses = 0;
    for (int i = 0; i < 100; i++) begin
      btn_left = ~btn_left;
      step();
      if (move_tick) moves++;
      if (phase != 3'd2) changes++;
      if (reset_actors || reset_board) pulses++;
    end
    btn_left = 1'b1;
    step();
    chk("freeze_moves", 0, moves);
    chk("freeze_state", 0, changes);
    chk("freeze_pulses", 0, pulses);
    game_active = 1'b1;
    push("resume_move", 4);
    wait_move(20, cyc); check(cyc);
    btn_left = 1'b0;
    chk("resume_phase", 2, int'(phase));

    // asynchronous reset in DYING
    hit = 1'b1;
    wait_phase(3, 20, cyc);
    hit = 1'b0;
    step(); step();
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_phase", 0, int'(phase));
    chk("async_rst_lives", 0, int'(lives));
    chk("async_rst_flags", 0, int'({game_over, move_tick, reset_actors, reset_board}));
    step(); step();
    rst_n = 1'b1;
    pulses = 0; changes = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (reset_actors || reset_board || move_tick) pulses++;
      if (phase != 3'd0) changes++;
    end
    chk("release_no_pulse", 0, pulses);
    chk("release_idle", 0, changes);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
